dmem_lsu: RTL and testbench

Load/store unit that turns core data requests into accesses on the word-only, byte-addressed 1R1W data memory. It sits between the core's memory stage and the data memory instance. Word stores write the memory directly. Sub-word stores are done as read-modify-write, because the memory has no byte enables. Loads are lane-extracted and sign- or zero-extended. Misaligned and illegal requests return an error without touching memory.

---
 rtl/dmem_lsu.sv | 184 ++++++++++++++++++
 tb/tb_dmem_lsu.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/dmem_lsu.sv
// Load/store unit between the core memory stage and a word-only 1R1W data memory.
// Sub-word stores are read-modify-write; loads are lane-extracted and extended.
module dmem_lsu #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADDR_W = $clog2(DEPTH) + 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic [31:0]       mem_rd_dout,
  output logic [ADDR_W-1:0] mem_wr_addr,
  output logic [31:0]       mem_wr_din,
  output logic              mem_we
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_READ,
    S_WRITE,
    S_RESP
  } state_t;

  state_t              state_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [2:0]          funct3_q;
  logic                we_q;
  logic [31:0]         wdata_q;
  logic [31:0]         old_word_q;
  logic [31:0]         rdata_q;
  logic                err_q;
  logic                resp_valid_q;
  logic                ready_q;
  logic                mem_we_q;
  logic [ADDR_W-1:0]   aligned_addr;
  logic [31:0]         merged_d;

  function automatic logic req_illegal(input logic we, input logic [2:0] f3,
                                       input logic [1:0] a);
    logic bad;
    bad = 1'b1;
    if (we) begin
      case (f3)
        3'b000:  bad = 1'b0;
        3'b001:  bad = a[0];
        3'b010:  bad = |a;
        default: bad = 1'b1;
      endcase
    end else begin
      case (f3)
        3'b000, 3'b100: bad = 1'b0;
        3'b001, 3'b101: bad = a[0];
        3'b010:         bad = |a;
        default:        bad = 1'b1;
      endcase
    end
    return bad;
  endfunction

  function automatic logic [31:0] lane_extract(input logic [2:0] f3, input logic [1:0] off,
                                               input logic [31:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (off)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    h = off[1] ? word[31:16] : word[15:0];
    case (f3)
      3'b000:  r = {{24{b[7]}}, b};
      3'b100:  r = {24'd0, b};
      3'b001:  r = {{16{h[15]}}, h};
      3'b101:  r = {16'd0, h};
      default: r = word;
    endcase
    return r;
  endfunction

  assign aligned_addr = {addr_q[ADDR_W-1:2], 2'b00};

  always_comb begin
    merged_d = old_word_q;
    case (funct3_q[1:0])
      2'b00:   merged_d[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
      2'b01:   merged_d[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
      default: merged_d = wdata_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      addr_q       <= '0;
      funct3_q     <= '0;
      we_q         <= 1'b0;
      wdata_q      <= '0;
      old_word_q   <= '0;
      rdata_q      <= '0;
      err_q        <= 1'b0;
      resp_valid_q <= 1'b0;
      ready_q      <= 1'b1;
      mem_we_q     <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          resp_valid_q <= 1'b0;
          if (req_valid && ready_q) begin
            addr_q   <= req_addr;
            funct3_q <= req_funct3;
            we_q     <= req_we;
            wdata_q  <= req_wdata;
            ready_q  <= 1'b0;
            if (req_illegal(req_we, req_funct3, req_addr[1:0])) begin
              rdata_q      <= '0;
              err_q        <= 1'b1;
              resp_valid_q <= 1'b1;
              state_q      <= S_RESP;
            end else if (!req_we) begin
              state_q <= S_LOAD;
            end else if (req_funct3 == 3'b010) begin
              mem_we_q <= 1'b1;
              state_q  <= S_WRITE;
            end else begin
              state_q <= S_READ;
            end
          end
        end
        S_LOAD: begin
          rdata_q      <= lane_extract(funct3_q, addr_q[1:0], mem_rd_dout);
          err_q        <= 1'b0;
          resp_valid_q <= 1'b1;
          state_q      <= S_RESP;
        end
        S_READ: begin
          old_word_q <= mem_rd_dout;
          mem_we_q   <= 1'b1;
          state_q    <= S_WRITE;
        end
        S_WRITE: begin
          mem_we_q     <= 1'b0;
          rdata_q      <= '0;
          err_q        <= 1'b0;
          resp_valid_q <= 1'b1;
          state_q      <= S_RESP;
        end
        S_RESP: begin
          resp_valid_q <= 1'b0;
          ready_q      <= 1'b1;
          state_q      <= S_IDLE;
        end
        default: begin
          resp_valid_q <= 1'b0;
          mem_we_q     <= 1'b0;
          ready_q      <= 1'b1;
          state_q      <= S_IDLE;
        end
      endcase
    end
  end

  // Reset masks the handshake/write strobes combinationally so an asserted
  // reset during WRITE suppresses the memory write in that same cycle.
  assign req_ready   = ready_q & ~rst;
  assign resp_valid  = resp_valid_q & ~rst;
  assign resp_err    = err_q & ~rst;
  assign mem_we      = mem_we_q & ~rst;
  assign resp_rdata  = rdata_q;
  assign mem_rd_addr = (state_q == S_LOAD || state_q == S_READ) ? aligned_addr : '0;
  assign mem_wr_addr = (state_q == S_WRITE) ? aligned_addr : '0;
  assign mem_wr_din  = (state_q == S_WRITE && we_q) ? merged_d : '0;

endmodule

// File: tb/tb_dmem_lsu.sv
// Directed bench for dmem_lsu with a 4-word backing memory and hand-computed results.
module tb_dmem_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [3:0]  req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [3:0]  mem_rd_addr;
  logic [31:0] mem_rd_dout;
  logic [3:0]  mem_wr_addr;
  logic [31:0] mem_wr_din;
  logic        mem_we;

  logic [31:0] mem [4];
  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  dmem_lsu #(.DEPTH(4), .ADDR_W(4)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_rd_addr(mem_rd_addr), .mem_rd_dout(mem_rd_dout),
    .mem_wr_addr(mem_wr_addr), .mem_wr_din(mem_wr_din), .mem_we(mem_we)
  );

  always #5 clk = ~clk;

  assign mem_rd_dout = mem[mem_rd_addr[3:2]];
  always @(posedge clk) if (mem_we) mem[mem_wr_addr[3:2]] <= mem_wr_din;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Latency counts falling edges after the accept edge until resp_valid is seen.
  task automatic run_req(input string tag, input logic we, input logic [2:0] f3,
                         input logic [3:0] addr, input logic [31:0] wd,
                         input logic [31:0] exp_rd, input logic exp_err,
                         input int exp_lat, input int exp_we_n,
                         output logic [31:0] wa, output logic [31:0] wdv);
    int lat;
    int we_n;
    logic [31:0] rd;
    logic er;
    lat = 0; we_n = 0; rd = '0; er = 1'b0; wa = '0; wdv = '0;
    @(negedge clk);
    check({tag, ".ready"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    @(posedge clk);
    #1 req_valid = 1'b0;
    for (int cyc = 1; cyc <= 8; cyc++) begin
      @(negedge clk);
      if (mem_we) begin
        we_n++;
        wa  = 32'(mem_wr_addr);
        wdv = mem_wr_din;
      end
      if (resp_valid) begin
        lat = cyc; rd = resp_rdata; er = resp_err;
        break;
      end
    end
    check({tag, ".lat"}, 32'(lat), 32'(exp_lat));
    check({tag, ".rdata"}, rd, exp_rd);
    check({tag, ".err"}, 32'(er), 32'(exp_err));
    check({tag, ".we_n"}, 32'(we_n), 32'(exp_we_n));
  endtask

  logic [31:0] wa, wdv;
  logic        bw_we [4];
  logic [2:0]  bw_f3 [4];
  logic [3:0]  bw_ad [4];
  logic [31:0] bw_wd [4];
  int          acc_c [4];
  int          rsp_c [4];
  logic [31:0] rsp_d [4];
  int          ai, ri;
  logic        acc;
  int          rv_seen;

  initial begin
    for (int i = 0; i < 4; i++) mem[i] = '0;
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = '0; req_addr = '0; req_wdata = '0;
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    check("rst.ready", 32'(req_ready), 32'd0);
    check("rst.resp_valid", 32'(resp_valid), 32'd0);
    check("rst.mem_we", 32'(mem_we), 32'd0);
    rst = 1'b0;
    #1;
    check("idle.ready", 32'(req_ready), 32'd1);
    check("idle.rd_addr", 32'(mem_rd_addr), 32'd0);
    check("idle.wr_addr", 32'(mem_wr_addr), 32'd0);
    check("idle.wr_din", mem_wr_din, 32'd0);
    check("idle.rdata", resp_rdata, 32'd0);

    run_req("sw4", 1'b1, 3'b010, 4'h4, 32'hDEADBEEF, 32'd0, 1'b0, 2, 1, wa, wdv);
    check("sw4.wr_addr", wa, 32'h4);
    check("sw4.wr_din", wdv, 32'hDEADBEEF);
    run_req("lw4", 1'b0, 3'b010, 4'h4, 32'd0, 32'hDEADBEEF, 1'b0, 2, 0, wa, wdv);

    run_req("sb6", 1'b1, 3'b000, 4'h6, 32'h00000011, 32'd0, 1'b0, 3, 1, wa, wdv);
    check("sb6.wr_addr", wa, 32'h4);
    check("sb6.wr_din", wdv, 32'hDE11BEEF);
    run_req("lw4b", 1'b0, 3'b010, 4'h4, 32'd0, 32'hDE11BEEF, 1'b0, 2, 0, wa, wdv);
    run_req("sh4", 1'b1, 3'b001, 4'h4, 32'h00002233, 32'd0, 1'b0, 3, 1, wa, wdv);
    check("sh4.wr_din", wdv, 32'hDE112233);
    run_req("lw4c", 1'b0, 3'b010, 4'h4, 32'd0, 32'hDE112233, 1'b0, 2, 0, wa, wdv);

    run_req("sw8", 1'b1, 3'b010, 4'h8, 32'h80FF7F01, 32'd0, 1'b0, 2, 1, wa, wdv);
    run_req("lbB", 1'b0, 3'b000, 4'hB, 32'd0, 32'hFFFFFF80, 1'b0, 2, 0, wa, wdv);
    run_req("lbuB", 1'b0, 3'b100, 4'hB, 32'd0, 32'h00000080, 1'b0, 2, 0, wa, wdv);
    run_req("lb9", 1'b0, 3'b000, 4'h9, 32'd0, 32'h0000007F, 1'b0, 2, 0, wa, wdv);
    run_req("lbA", 1'b0, 3'b000, 4'hA, 32'd0, 32'hFFFFFFFF, 1'b0, 2, 0, wa, wdv);
    run_req("lhA", 1'b0, 3'b001, 4'hA, 32'd0, 32'hFFFF80FF, 1'b0, 2, 0, wa, wdv);
    run_req("lhuA", 1'b0, 3'b101, 4'hA, 32'd0, 32'h000080FF, 1'b0, 2, 0, wa, wdv);
    run_req("lhu8", 1'b0, 3'b101, 4'h8, 32'd0, 32'h00007F01, 1'b0, 2, 0, wa, wdv);

    run_req("err.lw5", 1'b0, 3'b010, 4'h5, 32'd0, 32'd0, 1'b1, 1, 0, wa, wdv);
    run_req("err.sh3", 1'b1, 3'b001, 4'h3, 32'h0000ABCD, 32'd0, 1'b1, 1, 0, wa, wdv);
    run_req("err.ld011", 1'b0, 3'b011, 4'h4, 32'd0, 32'd0, 1'b1, 1, 0, wa, wdv);
    run_req("err.st100", 1'b1, 3'b100, 4'h4, 32'h12345678, 32'd0, 1'b1, 1, 0, wa, wdv);
    run_req("err.sw6", 1'b1, 3'b010, 4'h6, 32'h12345678, 32'd0, 1'b1, 1, 0, wa, wdv);
    run_req("lw4d", 1'b0, 3'b010, 4'h4, 32'd0, 32'hDE112233, 1'b0, 2, 0, wa, wdv);

    // Back-to-back with req_valid held high: LW, SB, LW, SB on word 0x4.
    bw_we[0] = 1'b0; bw_f3[0] = 3'b010; bw_ad[0] = 4'h4; bw_wd[0] = 32'd0;
    bw_we[1] = 1'b1; bw_f3[1] = 3'b000; bw_ad[1] = 4'h5; bw_wd[1] = 32'h00000066;
    bw_we[2] = 1'b0; bw_f3[2] = 3'b010; bw_ad[2] = 4'h4; bw_wd[2] = 32'd0;
    bw_we[3] = 1'b1; bw_f3[3] = 3'b000; bw_ad[3] = 4'h4; bw_wd[3] = 32'h00000077;
    for (int i = 0; i < 4; i++) begin acc_c[i] = 0; rsp_c[i] = 0; rsp_d[i] = 'x; end
    ai = 0; ri = 0;
    @(negedge clk);
    req_valid = 1'b1; req_we = bw_we[0]; req_funct3 = bw_f3[0]; req_addr = bw_ad[0]; req_wdata = bw_wd[0];
    for (int c = 0; c < 40; c++) begin
      if (resp_valid && ri < 4) begin
        rsp_c[ri] = c; rsp_d[ri] = resp_rdata; ri++;
      end
      acc = req_valid && req_ready;
      @(posedge clk);
      #1;
      if (acc) begin
        acc_c[ai] = c; ai++;
        if (ai < 4) begin
          req_we = bw_we[ai]; req_funct3 = bw_f3[ai]; req_addr = bw_ad[ai]; req_wdata = bw_wd[ai];
        end else begin
          req_valid = 1'b0;
        end
      end
      @(negedge clk);
    end
    check("b2b.accepts", 32'(ai), 32'd4);
    check("b2b.resps", 32'(ri), 32'd4);
    check("b2b.acc01", 32'(acc_c[1] - acc_c[0]), 32'd3);
    check("b2b.acc12", 32'(acc_c[2] - acc_c[1]), 32'd4);
    check("b2b.acc23", 32'(acc_c[3] - acc_c[2]), 32'd3);
    check("b2b.rsp01", 32'(rsp_c[1] - rsp_c[0]), 32'd4);
    check("b2b.rsp12", 32'(rsp_c[2] - rsp_c[1]), 32'd3);
    check("b2b.rsp23", 32'(rsp_c[3] - rsp_c[2]), 32'd4);
    check("b2b.rd0", rsp_d[0], 32'hDE112233);
    check("b2b.rd1", rsp_d[1], 32'd0);
    check("b2b.rd2", rsp_d[2], 32'hDE116633);
    check("b2b.rd3", rsp_d[3], 32'd0);
    run_req("lw4e", 1'b0, 3'b010, 4'h4, 32'd0, 32'hDE116677, 1'b0, 2, 0, wa, wdv);

    // Reset while an SB sits in WRITE: no write, no response.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b000; req_addr = 4'h7; req_wdata = 32'h000000AA;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rstw.we_before", 32'(mem_we), 32'd1);
    rst = 1'b1;
    #1;
    check("rstw.we_gated", 32'(mem_we), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rstw.ready", 32'(req_ready), 32'd1);
    rv_seen = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (resp_valid) rv_seen++;
    end
    check("rstw.no_resp", 32'(rv_seen), 32'd0);
    run_req("lw4f", 1'b0, 3'b010, 4'h4, 32'd0, 32'hDE116677, 1'b0, 2, 0, wa, wdv);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
